// File: rtl/meganode_pkg.sv
// Shared definitions for the meganode top level: SSI reader state encoding,
// default SSI frame constants and a parity helper.
package meganode_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOW     = 2'd1,
    HIGH    = 2'd2,
    RECOVER = 2'd3
  } ssi_state_t;

  localparam int SSI_NBITS    = 18;
  localparam int SSI_CLK_DIV  = 10;
  localparam int SSI_RECOVERY = 400;

  // Reduction XOR over a zero-extended frame; 1 means odd parity.
  function automatic logic parity33(input logic [32:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ssi_encoder_reader_if.sv
// Host-side bundle of the SSI reader: frame request in, position/status out.
interface ssi_encoder_reader_if #(
  parameter int NBITS = meganode_pkg::SSI_NBITS
);
  logic             start;
  logic [NBITS-1:0] pos;
  logic             pos_valid;
  logic             busy;
  logic             err;

  modport master (output start, input pos, input pos_valid, input busy, input err);
  modport slave  (input start, output pos, output pos_valid, output busy, output err);
endinterface

// File: rtl/sync2.sv
// Generic two-flop synchronizer with a parameterized reset level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_r <= {2{RST_VAL}};
    end else begin
      ff_r <= {ff_r[0], d};
    end
  end

  assign q = ff_r[1];

endmodule

// File: rtl/ssi_encoder_reader.sv
// Master-side SSI reader: clocks out NB bits on mclk, latches the position word.
// Optional even parity bit after the data is enabled with `define SSI_PARITY_EN.
module ssi_encoder_reader
  import meganode_pkg::*;
#(
  parameter int NBITS    = SSI_NBITS,
  parameter int CLK_DIV  = SSI_CLK_DIV,
  parameter int RECOVERY = SSI_RECOVERY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mdata,
  output logic                 mclk,
  ssi_encoder_reader_if.slave  host
);

`ifdef SSI_PARITY_EN
  localparam int NB = NBITS + 1;
`else
  localparam int NB = NBITS;
`endif
  localparam int BCW     = $clog2(NB + 1);
  localparam int CNT_MAX = (CLK_DIV > RECOVERY) ? CLK_DIV : RECOVERY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_LOW     = 2'(LOW);
  localparam logic [1:0] ST_HIGH    = 2'(HIGH);
  localparam logic [1:0] ST_RECOVER = 2'(RECOVER);

  logic             mdata_s;
  logic [1:0]       state_r,     state_nxt_s;
  logic [CW-1:0]    cnt_r,       cnt_nxt_s;
  logic [BCW-1:0]   bit_cnt_r,   bit_cnt_nxt_s;
  logic [NB-1:0]    shreg_r,     shreg_nxt_s;
  logic [NBITS-1:0] pos_r,       pos_nxt_s;
  logic             pos_valid_r, pos_valid_nxt_s;
  logic             err_r,       err_nxt_s;
  logic             busy_r,      busy_nxt_s;
  logic             mclk_r,      mclk_nxt_s;
  logic [NB-1:0]    shift_s;
  logic             div_last_s;
  logic             rec_last_s;
  logic             frame_last_s;

  sync2 #(.RST_VAL(1'b1)) u_mdata_sync (
    .clk (clk),
    .rst (rst),
    .d   (mdata),
    .q   (mdata_s)
  );

  assign shift_s      = {shreg_r[NB-2:0], mdata_s};
  assign div_last_s   = (cnt_r == CW'(CLK_DIV - 1));
  assign rec_last_s   = (cnt_r == CW'(RECOVERY - 1));
  assign frame_last_s = (bit_cnt_r == BCW'(NB - 1));

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    shreg_nxt_s     = shreg_r;
    pos_nxt_s       = pos_r;
    pos_valid_nxt_s = 1'b0;
    err_nxt_s       = 1'b0;
    busy_nxt_s      = busy_r;
    mclk_nxt_s      = 1'b1;

    case (state_r)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
        if (host.start) begin
          if (mdata_s) begin
            state_nxt_s   = ST_LOW;
            cnt_nxt_s     = CW'(0);
            bit_cnt_nxt_s = BCW'(0);
            busy_nxt_s    = 1'b1;
            mclk_nxt_s    = 1'b0;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_LOW: begin
        busy_nxt_s = 1'b1;
        if (div_last_s) begin
          state_nxt_s = ST_HIGH;
          cnt_nxt_s   = CW'(0);
          mclk_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s  = cnt_r + CW'(1);
          mclk_nxt_s = 1'b0;
        end
      end

      ST_HIGH: begin
        busy_nxt_s = 1'b1;
        if (div_last_s) begin
          shreg_nxt_s   = shift_s;
          bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
          cnt_nxt_s     = CW'(0);
          if (frame_last_s) begin
            // The final bit is folded in here so pos is valid on the first RECOVER cycle.
            state_nxt_s = ST_RECOVER;
`ifdef SSI_PARITY_EN
            if (parity33(33'(shift_s))) begin
              err_nxt_s = 1'b1;
            end else begin
              pos_nxt_s       = shift_s[NB-1:1];
              pos_valid_nxt_s = 1'b1;
            end
`else
            pos_nxt_s       = shift_s;
            pos_valid_nxt_s = 1'b1;
`endif
          end else begin
            state_nxt_s = ST_LOW;
            mclk_nxt_s  = 1'b0;
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end

      ST_RECOVER: begin
        busy_nxt_s = 1'b1;
        if (rec_last_s) begin
          // Last recovery clock behaves as IDLE so back-to-back frames lose no cycle.
          if (host.start && mdata_s) begin
            state_nxt_s   = ST_LOW;
            cnt_nxt_s     = CW'(0);
            bit_cnt_nxt_s = BCW'(0);
            mclk_nxt_s    = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
            busy_nxt_s  = 1'b0;
            err_nxt_s   = host.start;
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CW'(0);
      bit_cnt_r   <= BCW'(0);
      shreg_r     <= NB'(0);
      pos_r       <= NBITS'(0);
      pos_valid_r <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      mclk_r      <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      shreg_r     <= shreg_nxt_s;
      pos_r       <= pos_nxt_s;
      pos_valid_r <= pos_valid_nxt_s;
      err_r       <= err_nxt_s;
      busy_r      <= busy_nxt_s;
      mclk_r      <= mclk_nxt_s;
    end
  end

  assign mclk           = mclk_r;
  assign host.pos       = pos_r;
  assign host.pos_valid = pos_valid_r;
  assign host.busy      = busy_r;
  assign host.err       = err_r;

endmodule

// File: doc/ssi_encoder_reader.md
# ssi_encoder_reader

Master-side SSI reader for the absolute motor-angle encoder. It drives one `mclk` pin and samples the matching `mdata` pin, producing a latched position word and a one-cycle valid strobe for the commutation logic inside the `meganode` top level. It runs in the `clk_20` domain, and one instance is placed per motor channel (`mclk[i]`/`mdata[i]`).

## Interface
- `NBITS`, 18: position bits per frame, MSB first; legal range 8..32.
- `CLK_DIV`, 10: clocks per `mclk` half-period; must be at least 3. The default gives 1 MHz SSI at 20 MHz.
- `RECOVERY`, 400: clocks `mclk` is held high after a frame (20 µs monoflop time); must be at least 1.
- `clk` input 1: system clock (`clk_20`). One clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: frame request, sampled only in IDLE.
- `mdata` input 1: raw encoder data pin, asynchronous.
- `mclk` output 1: SSI clock; idles high.
- `pos` output NBITS: last good position.
- `pos_valid` output 1: one-cycle strobe; `pos` is updated on the same cycle.
- `busy` output 1: high from frame acceptance until RECOVER completes.
- `err` output 1: one-cycle error strobe.

## Operation
- `mdata` passes through a 2-FF synchronizer to `mdata_s`. The synchronizer resets to 1.
- States are IDLE, LOW, HIGH and RECOVER.
- **IDLE:**
  - `mclk` = 1 and `busy` = 0.
  - On `start` with `mdata_s` = 1: go to LOW; clear the bit counter and divider.
  - On `start` with `mdata_s` = 0 (encoder not ready or line fault): pulse `err` and stay in IDLE.
  - `start` outside IDLE is ignored; no queuing.
- **LOW:** `mclk` = 0 for CLK_DIV clocks, then go to HIGH.
- **HIGH:**
  - `mclk` = 1 for CLK_DIV clocks.
  - On the last HIGH clock, shift `mdata_s` into the shift register (MSB first) and increment the bit counter.
  - If bits remain, go to LOW. Otherwise go to RECOVER.
- **RECOVER:**
  - `mclk` = 1 for RECOVERY clocks, then go to IDLE.
  - On the first RECOVER cycle, copy the shift register to `pos` and pulse `pos_valid`, unless a parity error occurred (see Configuration).
- Frame length is NB = NBITS, or NBITS+1 with parity.
- The bit counter is wide enough for NB. The divider counts 0..CLK_DIV-1 and wraps on every phase change.
- Asynchronous `rst` mid-frame:
  - State returns to IDLE and `mclk` is forced to 1 immediately.
  - The partial frame is discarded and `pos` reverts to 0.
  - The encoder's own timeout recovers it; the next `start` must not come sooner than RECOVERY clocks after reset release. This is the caller's obligation.
- Reset values: `mclk` = 1, `pos` = 0, `pos_valid` = 0, `busy` = 0, `err` = 0.

## Timing
- `start` is sampled high at edge E0; `busy` and `mclk` = 0 take effect from E0.
- The k-th `mdata` sample (k = 1..NB) is taken at E0 + 2·CLK_DIV·k − 1.
- `pos_valid` and `pos` update at E0 + 2·CLK_DIV·NB.
- `busy` falls at E0 + 2·CLK_DIV·NB + RECOVERY. `start` is accepted again at that same edge.
- Data path latency: the encoder must present each bit within CLK_DIV − 2 clocks after the `mclk` rising edge, because of the 2-FF synchronizer.
- `err` and `pos_valid` are never asserted on the same cycle.

## Configuration
- `SSI_PARITY_EN` defined:
  - An even-parity bit follows the NBITS data bits (NB = NBITS+1).
  - If parity over data plus parity bit is odd: on the first RECOVER cycle, pulse `err` instead of `pos_valid`, and leave `pos` unchanged.
  - RECOVER still runs in full.
- `SSI_PARITY_EN` undefined:
  - NB = NBITS and there is no parity logic.
  - `err` is driven only by the not-ready check in IDLE.

## Structure
- Shared package `meganode_pkg` holds:
  - the `ssi_state_t` enum (IDLE, LOW, HIGH, RECOVER);
  - the default constants SSI_NBITS = 18, SSI_CLK_DIV = 10 and SSI_RECOVERY = 400.
- Sub-module `sync2`: a generic 2-FF synchronizer with parameterized reset value. It is instantiated for `mdata` and is reusable for `mcu_io` and the SPI slave inputs.

## Test plan
- Parameters CLK_DIV = 3, NBITS = 18, RECOVERY = 10, no parity. The model shifts out 0x2A5C3 on `mclk` rising edges, and `start` is pulsed at E0.
  - `pos` = 0x2A5C3 and `pos_valid` high for exactly one cycle at E0 + 108.
  - `busy` falls at E0 + 118.
  - Exactly 18 `mclk` falling edges.
- `mdata` held low while `start` is pulsed: `err` pulses one cycle later, `mclk` stays 1, `busy` stays 0.
- `start` pulsed repeatedly during a frame and during RECOVER: no extra `mclk` edges; the frame completes unchanged.
- `rst` asserted at bit 7: `mclk` goes to 1 asynchronously, `pos` = 0, no `pos_valid`. A new frame after reset release plus RECOVERY clocks reads correctly.
- `SSI_PARITY_EN`, data 0x00001:
  - With parity bit 1: `pos_valid` and `pos` = 0x00001.
  - With parity bit 0: `err` pulses and `pos` keeps its previous value.
- Back-to-back frames with `start` tied high: frame starts are spaced exactly 2·CLK_DIV·NB + RECOVERY clocks apart.
